// File: rtl/spi_master_param.sv
// Parametrised SPI master: one DATA_W-bit full-duplex frame per accepted word, with configurable
// SCLK divider, CPOL/CPHA mode, bit order and chip-select gap.
module spi_master_param #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned CS_GAP    = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic [DATA_W-1:0]               tx_data,
  input  logic                            spi_miso,
  output logic                            rx_valid,
  output logic [DATA_W-1:0]               rx_data,
  output logic                            busy,
  output logic                            spi_cs_l,
  output logic                            spi_clk,
  output logic                            spi_data,
  output logic [$clog2(DATA_W+1)-1:0]     counter
);

  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
  localparam int unsigned TGL_W   = $clog2(2 * DATA_W + 1);
  localparam int unsigned TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic        IDLE_CLK = (CPOL != 0);

  typedef enum logic [2:0] {StIdle, StLead, StShift, StTrail, StGap} state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q;
  logic [TGL_W-1:0]    tgl_q, tgl_next;
  logic [DATA_W-1:0]   tx_sr_q, rx_sr_q, rx_data_q;
  logic [CNT_W-1:0]    counter_q;
  logic                spi_clk_q, spi_data_q, rx_valid_q;
  logic                accept, tmr_done, last_tgl, do_toggle, leading;
  logic                sample_edge, shift_edge;

  // Phase timer: one SCLK half-period in LEAD/SHIFT/TRAIL, CS_GAP cycles in GAP.
  always_comb begin
    accept    = (state_q == StIdle) && tx_valid;
    tmr_done  = (state_q == StGap) ? (tmr_q == TMR_W'(CS_GAP - 1))
                                   : (tmr_q == TMR_W'(CLK_DIV - 1));
    last_tgl  = (tgl_q == TGL_W'(2 * DATA_W));
    do_toggle = tmr_done && ((state_q == StLead) || ((state_q == StShift) && !last_tgl));
    tgl_next  = tgl_q + TGL_W'(1);
    leading   = tgl_next[0];
    if (CPHA == 0) begin
      sample_edge = do_toggle && leading;
      shift_edge  = do_toggle && !leading && (tgl_next != TGL_W'(2 * DATA_W));
    end else begin
      sample_edge = do_toggle && !leading;
      shift_edge  = do_toggle && leading && (tgl_next != TGL_W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (tx_valid)              state_d = StLead;
      StLead:  if (tmr_done)              state_d = StShift;
      StShift: if (tmr_done && last_tgl)  state_d = StTrail;
      StTrail: if (tmr_done)              state_d = StGap;
      StGap:   if (tmr_done)              state_d = StIdle;
      default:                            state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
    spi_cs_l = !((state_q == StLead) || (state_q == StShift) || (state_q == StTrail));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_q      <= '0;
      tgl_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      counter_q  <= '0;
      spi_clk_q  <= IDLE_CLK;
      spi_data_q <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      tmr_q      <= ((state_d != state_q) || tmr_done) ? '0 : tmr_q + TMR_W'(1);
      rx_valid_q <= (state_q == StTrail) && tmr_done;
      if ((state_q == StTrail) && tmr_done) rx_data_q <= rx_sr_q;
      if (accept) begin
        tgl_q      <= '0;
        counter_q  <= '0;
        tx_sr_q    <= tx_data;
        spi_data_q <= (MSB_FIRST != 0) ? tx_data[DATA_W-1] : tx_data[0];
      end else begin
        if (do_toggle) begin
          tgl_q     <= tgl_next;
          spi_clk_q <= ~spi_clk_q;
        end
        if (sample_edge) begin
          counter_q <= counter_q + CNT_W'(1);
          rx_sr_q   <= (MSB_FIRST != 0) ? {rx_sr_q[DATA_W-2:0], spi_miso}
                                        : {spi_miso, rx_sr_q[DATA_W-1:1]};
        end
        // tx_sr_q keeps the current bit at its output end; spi_data_q mirrors it.
        if (shift_edge) begin
          tx_sr_q    <= (MSB_FIRST != 0) ? {tx_sr_q[DATA_W-2:0], 1'b0}
                                         : {1'b0, tx_sr_q[DATA_W-1:1]};
          spi_data_q <= (MSB_FIRST != 0) ? tx_sr_q[DATA_W-2] : tx_sr_q[1];
        end
      end
    end
  end

  assign spi_clk  = spi_clk_q;
  assign spi_data = spi_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign counter  = counter_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: three configurations (defaults/loopback, mode 3, 8-bit LSB-first)
// checked against frame-level expectations computed from the word and MISO pattern.
module tb_spi_master_param;

  logic clk, reset;
  int   tests_run, tests_failed;

  // Default configuration, MISO looped back from MOSI.
  logic        tx_valid0, tx_ready0, rx_valid0, busy0, spi_cs_l0, spi_clk0, spi_data0;
  logic [15:0] tx_data0, rx_data0;
  logic [4:0]  counter0;
  // CPOL=1, CPHA=1, MISO tied high.
  logic        tx_valid1, tx_ready1, rx_valid1, busy1, spi_cs_l1, spi_clk1, spi_data1;
  logic [15:0] tx_data1, rx_data1;
  logic [4:0]  counter1;
  // DATA_W=8, CLK_DIV=1, LSB first, MISO driven by the bench.
  logic        tx_valid2, tx_ready2, rx_valid2, busy2, spi_cs_l2, spi_clk2, spi_data2, miso2;
  logic [7:0]  tx_data2, rx_data2;
  logic [3:0]  counter2;

  spi_master_param u_dut0 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_data(tx_data0),
    .spi_miso(spi_data0), .rx_valid(rx_valid0), .rx_data(rx_data0), .busy(busy0),
    .spi_cs_l(spi_cs_l0), .spi_clk(spi_clk0), .spi_data(spi_data0), .counter(counter0)
  );

  spi_master_param #(.CPOL(1), .CPHA(1)) u_dut1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_data(tx_data1),
    .spi_miso(1'b1), .rx_valid(rx_valid1), .rx_data(rx_data1), .busy(busy1),
    .spi_cs_l(spi_cs_l1), .spi_clk(spi_clk1), .spi_data(spi_data1), .counter(counter1)
  );

  spi_master_param #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0)) u_dut2 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2),
    .spi_miso(miso2), .rx_valid(rx_valid2), .rx_data(rx_data2), .busy(busy2),
    .spi_cs_l(spi_cs_l2), .spi_clk(spi_clk2), .spi_data(spi_data2), .counter(counter2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One default-config frame; MOSI captured MSB first at rising SCLK edges.
  task automatic frame0(input logic [15:0] w, output int cs_low, output logic [15:0] mosi,
                        output int n_rise, output int n_valid, output logic [15:0] rx);
    logic prev_clk;
    int   guard;
    @(negedge clk);
    tx_valid0 = 1'b1;
    tx_data0  = w;
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_data0  = 16'($urandom);
    cs_low = 0; mosi = '0; n_rise = 0; n_valid = 0; rx = '0; guard = 0;
    prev_clk = spi_clk0;
    while (!spi_cs_l0 && guard < 500) begin
      cs_low++;
      if (!prev_clk && spi_clk0) begin
        n_rise++;
        mosi = {mosi[14:0], spi_data0};
      end
      prev_clk = spi_clk0;
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 4; i++) begin
      if (rx_valid0) begin
        n_valid++;
        rx = rx_data0;
      end
      @(negedge clk);
    end
  endtask

  // Mode-3 frame; the slave samples on rising SCLK, so MOSI is captured there.
  task automatic frame1(input logic [15:0] w, output int cs_low, output logic first_bit,
                        output logic [15:0] mosi, output int n_rise, output int n_valid,
                        output logic [15:0] rx);
    logic prev_clk;
    int   guard;
    @(negedge clk);
    tx_valid1 = 1'b1;
    tx_data1  = w;
    @(negedge clk);
    tx_valid1 = 1'b0;
    tx_data1  = ~w;
    cs_low = 0; mosi = '0; n_rise = 0; n_valid = 0; rx = '0; guard = 0;
    first_bit = spi_data1;
    prev_clk  = spi_clk1;
    while (!spi_cs_l1 && guard < 500) begin
      cs_low++;
      if (!prev_clk && spi_clk1) begin
        n_rise++;
        mosi = {mosi[14:0], spi_data1};
      end
      prev_clk = spi_clk1;
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 4; i++) begin
      if (rx_valid1) begin
        n_valid++;
        rx = rx_data1;
      end
      @(negedge clk);
    end
  endtask

  // 8-bit LSB-first frame; the bench acts as a mode-0 slave shifting pat out LSB first.
  task automatic frame2(input logic [7:0] tx, input logic [7:0] pat, output int cs_low,
                        output logic [7:0] mosi, output int n_valid, output logic [7:0] rx);
    logic prev_clk;
    int   guard, bit_idx;
    @(negedge clk);
    miso2     = pat[0];
    tx_valid2 = 1'b1;
    tx_data2  = tx;
    @(negedge clk);
    tx_valid2 = 1'b0;
    tx_data2  = ~tx;
    cs_low = 0; mosi = '0; n_valid = 0; rx = '0; guard = 0; bit_idx = 0;
    prev_clk = spi_clk2;
    while (!spi_cs_l2 && guard < 200) begin
      cs_low++;
      if (!prev_clk && spi_clk2) mosi = {spi_data2, mosi[7:1]};
      if (prev_clk && !spi_clk2 && bit_idx < 7) begin
        bit_idx++;
        miso2 = pat[bit_idx];
      end
      prev_clk = spi_clk2;
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 4; i++) begin
      if (rx_valid2) begin
        n_valid++;
        rx = rx_data2;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({spi_cs_l0, spi_clk0, spi_data0, tx_ready0, busy0, rx_valid0} !== 6'b100100) begin
      tests_failed++;
      $display("FAIL reset_ctl0: got %b want 100100",
               {spi_cs_l0, spi_clk0, spi_data0, tx_ready0, busy0, rx_valid0});
    end
    tests_run++;
    if (rx_data0 !== 16'h0 || counter0 !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_data0: rx_data %h counter %0d want 0 0", rx_data0, counter0);
    end
    tests_run++;
    if (spi_clk1 !== 1'b1 || spi_cs_l1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_cpol1: spi_clk %b cs_l %b want 1 1", spi_clk1, spi_cs_l1);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback_a569();
    int          cs_low, n_rise, n_valid;
    logic [15:0] mosi, rx, w;
    w = 16'hA569;
    frame0(w, cs_low, mosi, n_rise, n_valid, rx);
    tests_run++;
    if (n_rise !== 16) begin
      tests_failed++;
      $display("FAIL a569_rises: got %0d want 16", n_rise);
    end
    tests_run++;
    if (mosi !== w) begin
      tests_failed++;
      $display("FAIL a569_mosi: got %h want %h", mosi, w);
    end
    tests_run++;
    if (cs_low !== 68) begin
      tests_failed++;
      $display("FAIL a569_cs_low: got %0d want 68", cs_low);
    end
    tests_run++;
    if (n_valid !== 1 || rx !== w) begin
      tests_failed++;
      $display("FAIL a569_rx: got %h x%0d want %h x1", rx, n_valid, w);
    end
    tests_run++;
    if (counter0 !== 5'd16) begin
      tests_failed++;
      $display("FAIL a569_counter: got %0d want 16", counter0);
    end
  endtask

  task automatic test_random_loopback();
    int          cs_low, n_rise, n_valid;
    logic [15:0] mosi, rx, w;
    for (int k = 0; k < 5; k++) begin
      w = 16'($urandom);
      frame0(w, cs_low, mosi, n_rise, n_valid, rx);
      tests_run++;
      if (mosi !== w || rx !== w || n_valid !== 1 || cs_low !== 68) begin
        tests_failed++;
        $display("FAIL rand_loop: word %h got mosi %h rx %h x%0d cs_low %0d want %h %h x1 68",
                 w, mosi, rx, n_valid, cs_low, w, w);
      end
    end
  endtask

  task automatic test_mode3();
    int          cs_low, n_rise, n_valid;
    logic        first_bit;
    logic [15:0] mosi, rx, w;
    w = 16'h2563;
    tests_run++;
    if (spi_clk1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mode3_idle_clk: got %b want 1", spi_clk1);
    end
    frame1(w, cs_low, first_bit, mosi, n_rise, n_valid, rx);
    tests_run++;
    if (first_bit !== w[15]) begin
      tests_failed++;
      $display("FAIL mode3_first_bit: got %b want %b", first_bit, w[15]);
    end
    tests_run++;
    if (mosi !== w || n_rise !== 16) begin
      tests_failed++;
      $display("FAIL mode3_mosi: got %h (%0d rises) want %h (16)", mosi, n_rise, w);
    end
    tests_run++;
    if (rx !== 16'hFFFF || n_valid !== 1) begin
      tests_failed++;
      $display("FAIL mode3_rx: got %h x%0d want ffff x1", rx, n_valid);
    end
    tests_run++;
    if (cs_low !== 68 || spi_clk1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mode3_frame: cs_low %0d clk %b want 68 1", cs_low, spi_clk1);
    end
  endtask

  task automatic test_back_to_back();
    int          cyc, highs, falls[$];
    logic [15:0] rxq[$];
    logic        prev_cs;
    cyc = 0; highs = 0; prev_cs = 1'b1;
    @(negedge clk);
    tx_valid0 = 1'b1;
    tx_data0  = 16'h9B63;
    while (rxq.size() < 2 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_cs && !spi_cs_l0) begin
        falls.push_back(cyc);
        if (falls.size() == 1) tx_data0 = 16'h6A61;
        else                   tx_valid0 = 1'b0;
      end
      if (falls.size() == 1 && spi_cs_l0) highs++;
      if (rx_valid0) rxq.push_back(rx_data0);
      prev_cs = spi_cs_l0;
    end
    tx_valid0 = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (falls.size() < 2 || (falls[1] - falls[0]) !== 70) begin
      tests_failed++;
      $display("FAIL b2b_period: got %0d falls, spacing %0d want 70", falls.size(),
               (falls.size() < 2) ? -1 : falls[1] - falls[0]);
    end
    // Frame period minus the CS-low time: the GAP cycle plus the re-accept cycle.
    tests_run++;
    if (highs !== 70 - 68) begin
      tests_failed++;
      $display("FAIL b2b_cs_high: got %0d want %0d", highs, 70 - 68);
    end
    tests_run++;
    if (rxq.size() < 2 || rxq[0] !== 16'h9B63 || rxq[1] !== 16'h6A61) begin
      tests_failed++;
      $display("FAIL b2b_rx: got %0d words %h %h want 9b63 6a61", rxq.size(),
               (rxq.size() > 0) ? rxq[0] : 16'hx, (rxq.size() > 1) ? rxq[1] : 16'hx);
    end
  endtask

  task automatic test_lsb_div1();
    int         cs_low, n_valid;
    logic [7:0] mosi, rx;
    frame2(8'h01, 8'hC3, cs_low, mosi, n_valid, rx);
    tests_run++;
    if (mosi !== 8'h01) begin
      tests_failed++;
      $display("FAIL lsb_mosi: got %h (LSB first) want 01", mosi);
    end
    tests_run++;
    if (cs_low !== 18) begin
      tests_failed++;
      $display("FAIL lsb_cs_low: got %0d want 18", cs_low);
    end
    tests_run++;
    if (rx !== 8'hC3 || n_valid !== 1) begin
      tests_failed++;
      $display("FAIL lsb_rx: got %h x%0d want c3 x1", rx, n_valid);
    end
    tests_run++;
    if (counter2 !== 4'd8) begin
      tests_failed++;
      $display("FAIL lsb_counter: got %0d want 8", counter2);
    end
  endtask

  task automatic test_random_lsb();
    int         cs_low, n_valid;
    logic [7:0] mosi, rx, tx, pat;
    for (int k = 0; k < 4; k++) begin
      tx  = 8'($urandom);
      pat = 8'($urandom);
      frame2(tx, pat, cs_low, mosi, n_valid, rx);
      tests_run++;
      if (mosi !== tx || rx !== pat || n_valid !== 1) begin
        tests_failed++;
        $display("FAIL rand_lsb: tx %h pat %h got mosi %h rx %h x%0d", tx, pat, mosi, rx,
                 n_valid);
      end
    end
  endtask

  task automatic test_reset_abort();
    int          cs_low, n_rise, n_valid, stray_valid, stray_low;
    logic [15:0] mosi, rx;
    @(negedge clk);
    tx_valid0 = 1'b1;
    tx_data0  = 16'hA265;
    @(negedge clk);
    tx_valid0 = 1'b0;
    repeat (19) @(negedge clk);
    tests_run++;
    if (spi_cs_l0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_midframe: cs_l %b want 0", spi_cs_l0);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (spi_cs_l0 !== 1'b1 || spi_clk0 !== 1'b0 || counter0 !== 5'd0 || rx_valid0 !== 1'b0 ||
        busy0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_async: cs_l %b clk %b counter %0d rx_valid %b busy %b want 1 0 0 0 0",
               spi_cs_l0, spi_clk0, counter0, rx_valid0, busy0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stray_valid = 0;
    stray_low   = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rx_valid0) stray_valid++;
      if (!spi_cs_l0) stray_low++;
    end
    tests_run++;
    if (stray_valid !== 0 || stray_low !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_valid: rx_valid %0d cs_low %0d want 0 0", stray_valid, stray_low);
    end
    frame0(16'h7564, cs_low, mosi, n_rise, n_valid, rx);
    tests_run++;
    if (rx !== 16'h7564 || n_valid !== 1 || cs_low !== 68) begin
      tests_failed++;
      $display("FAIL abort_recover: rx %h x%0d cs_low %0d want 7564 x1 68", rx, n_valid, cs_low);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    tx_valid0 = 1'b0; tx_data0 = '0;
    tx_valid1 = 1'b0; tx_data1 = '0;
    tx_valid2 = 1'b0; tx_data2 = '0;
    miso2 = 1'b0;
    test_reset();
    test_loopback_a569();
    test_random_loopback();
    test_mode3();
    test_back_to_back();
    test_lsb_div1();
    test_random_lsb();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
